uart_reg_responder: RTL and testbench

Byte-level register-access responder that sits between `uart_rx` (command bytes in) and `uart_tx` (reply bytes out). It acts as the remote end of a host-driven serial register protocol. It decodes write and read commands, updates or reads a local bank of 8-bit registers, and returns exactly one reply byte per completed command. The register bank is exported flat so fabric logic can use it as host-programmed control registers.

---
 rtl/uart_reg_responder_if.sv | 20 ++
 rtl/uart_reg_responder.sv | 149 ++++++++++++++
 tb/tb_uart_reg_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_responder_if.sv
// uart_reg_responder_if: byte handshakes between the uart_rx/uart_tx side
// and the responder. master = host/uart side, slave = responder.
interface uart_reg_responder_if;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_data_ready;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_data_ready;

   modport master (
      output rx_data, rx_data_valid, tx_data_ready,
      input  rx_data_ready, tx_data, tx_data_valid
   );

   modport slave (
      input  rx_data, rx_data_valid, tx_data_ready,
      output rx_data_ready, tx_data, tx_data_valid
   );
endinterface

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: serial register-access responder (W addr data / R addr).
// Ports: clk, rst_n (sync, active-low), bus (uart_reg_responder_if.slave),
// regs_flat (reg i at [8i+7:8i]). Optional: UART_REG_RESP_TIMEOUT_EN.
module uart_reg_responder #(
   parameter int ADDR_W         = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   uart_reg_responder_if.slave        bus,
   output logic [8*(2**ADDR_W)-1:0]   regs_flat
);
   localparam int NREG = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t     state, state_d;
   logic       is_wr, is_wr_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] regs [NREG];

   logic       rx_ready, rx_ready_d;
   logic       tx_valid, tx_valid_d;
   logic [7:0] tx_data, tx_data_d;
   logic       wr_en;
   logic       rx_fire, tx_fire, tmo;

   assign rx_fire = bus.rx_data_valid & rx_ready;
   assign tx_fire = tx_valid & bus.tx_data_ready;

   assign bus.rx_data_ready = rx_ready;
   assign bus.tx_data_valid = tx_valid;
   assign bus.tx_data       = tx_data;

   function automatic logic in_range(input logic [7:0] a);
      return (a >> ADDR_W) == 8'd0;
   endfunction

`ifdef UART_REG_RESP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
   logic          waiting;

   assign waiting = (state == ADDR) || (state == DATA);
   // Fires on the edge where the count would reach TIMEOUT_CYCLES;
   // an accepted byte in the same cycle wins.
   assign tmo = waiting && !rx_fire &&
                (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (!waiting || rx_fire || tmo)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         is_wr    <= 1'b0;
         addr_q   <= 8'h00;
         rx_ready <= 1'b0;
         tx_valid <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         state    <= state_d;
         is_wr    <= is_wr_d;
         addr_q   <= addr_d;
         rx_ready <= rx_ready_d;
         tx_valid <= tx_valid_d;
         tx_data  <= tx_data_d;
      end
   end

   always_comb begin
      state_d = state;
      is_wr_d = is_wr;
      addr_d  = addr_q;
      unique case (state)
         IDLE:
            if (rx_fire) begin
               if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) begin
                  state_d = ADDR;
                  is_wr_d = (bus.rx_data == 8'h57);
               end else begin
                  state_d = RESP;
               end
            end
         ADDR:
            if (rx_fire) begin
               addr_d  = bus.rx_data;
               state_d = is_wr ? DATA : RESP;
            end else if (tmo) begin
               state_d = IDLE;
            end
         DATA:
            if (rx_fire)
               state_d = RESP;
            else if (tmo)
               state_d = IDLE;
         RESP:
            if (tx_fire)
               state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
   end

   // Registered outputs: next values follow the next state.
   always_comb begin
      rx_ready_d = (state_d != RESP);
      tx_valid_d = (state_d == RESP);
      tx_data_d  = tx_data;
      wr_en      = 1'b0;
      unique case (state)
         IDLE:
            if (rx_fire && state_d == RESP)
               tx_data_d = 8'h45;
         ADDR:
            if (rx_fire && !is_wr)
               tx_data_d = in_range(bus.rx_data) ?
                           regs[bus.rx_data[ADDR_W-1:0]] : 8'h45;
         DATA:
            if (rx_fire) begin
               wr_en     = in_range(addr_q);
               tx_data_d = in_range(addr_q) ? 8'h4B : 8'h45;
            end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= 8'h00;
      end else if (wr_en) begin
         regs[addr_q[ADDR_W-1:0]] <= bus.rx_data;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_flat
      assign regs_flat[8*g +: 8] = regs[g];
   end
endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: random command traffic against a register-bank
// model; checks replies, latency, backpressure, reset and bank contents.
module tb_uart_reg_responder;
   localparam int ADDR_W = 4;
   localparam int NREG   = 16;
`ifdef UART_REG_RESP_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 100000;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [127:0] regs_flat;

   always #5 clk = ~clk;

   uart_reg_responder_if ifc();

   uart_reg_responder #(
      .ADDR_W(ADDR_W),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(ifc),
      .regs_flat(regs_flat)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] mdl [NREG];

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] mdl_flat();
      logic [127:0] f;
      for (int i = 0; i < NREG; i++)
         f[8*i +: 8] = mdl[i];
      return f;
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < NREG; i++)
         mdl[i] = 8'h00;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, ifc.rx_data_ready, 1'b0);
      check({tag, "_tx_valid"}, ifc.tx_data_valid, 1'b0);
      check({tag, "_tx_data"}, ifc.tx_data, 8'h00);
      check({tag, "_regs"}, regs_flat, 128'h0);
   endtask

   // Called and returns at a negedge; byte accepted on the posedge between.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      ifc.rx_data = b;
      ifc.rx_data_valid = 1'b1;
      while (ifc.rx_data_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rx_ready_wait", n < 200, 1'b1);
      @(posedge clk);
      #1 ifc.rx_data_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   // Entered at the first cycle after the final byte was accepted.
   task automatic expect_reply(input logic [7:0] exp, input int stall);
      check("reply_valid", ifc.tx_data_valid, 1'b1);
      check("reply_data", ifc.tx_data, exp);
      check("resp_rx_ready", ifc.rx_data_ready, 1'b0);
      for (int i = 0; i < stall; i++) begin
         ifc.rx_data = 8'($urandom);
         ifc.rx_data_valid = 1'b1;
         @(negedge clk);
         check("stall_valid", ifc.tx_data_valid, 1'b1);
         check("stall_data", ifc.tx_data, exp);
         check("stall_rx_ready", ifc.rx_data_ready, 1'b0);
      end
      ifc.rx_data_valid = 1'b0;
      ifc.tx_data_ready = 1'b1;
      @(posedge clk);
      #1 ifc.tx_data_ready = 1'b0;
      @(negedge clk);
      check("post_tx_valid", ifc.tx_data_valid, 1'b0);
      check("post_rx_ready", ifc.rx_data_ready, 1'b1);
      check("bank", regs_flat, mdl_flat());
   endtask

   // kind 0 = write, 1 = read, 2 = other first byte
   task automatic do_cmd(input int kind, input logic [7:0] addr,
                         input logic [7:0] data, input int stall);
      logic [7:0] exp;
      if (kind == 0) begin
         send_byte(8'h57); gap();
         send_byte(addr);  gap();
         send_byte(data);
         if (addr < NREG) begin
            mdl[addr[3:0]] = data;
            exp = 8'h4B;
         end else begin
            exp = 8'h45;
         end
      end else if (kind == 1) begin
         send_byte(8'h52); gap();
         send_byte(addr);
         exp = (addr < NREG) ? mdl[addr[3:0]] : 8'h45;
      end else begin
         send_byte(data);
         exp = 8'h45;
      end
      expect_reply(exp, stall);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a, d;
      int         k;
      ifc.rx_data = 8'h00;
      ifc.rx_data_valid = 1'b0;
      ifc.tx_data_ready = 1'b0;
      mdl_clear();

      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release_ready", ifc.rx_data_ready, 1'b1);

      do_cmd(0, 8'h03, 8'hA5, 0);
      check("reg3", regs_flat[31:24], 8'hA5);
      do_cmd(1, 8'h03, 8'h00, 0);
      do_cmd(1, 8'h00, 8'h00, 1);
      do_cmd(2, 8'h00, 8'h3C, 0);
      do_cmd(0, 8'h1F, 8'h11, 0);
      do_cmd(1, 8'h03, 8'h00, 50);

      send_byte(8'h57);
      send_byte(8'h02);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      mdl_clear();
      @(negedge clk);
      check("midrst_ready", ifc.rx_data_ready, 1'b1);
      do_cmd(1, 8'h02, 8'h00, 0);

`ifdef UART_REG_RESP_TIMEOUT_EN
      send_byte(8'h52);
      repeat (TMO) begin
         check("tmo_no_reply", ifc.tx_data_valid, 1'b0);
         @(negedge clk);
      end
      check("tmo_ready", ifc.rx_data_ready, 1'b1);
      do_cmd(1, 8'h03, 8'h00, 0);
`endif

      for (int n = 0; n < 300; n++) begin
         k = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255))
                                         : 8'($urandom_range(0, 15));
         d = 8'($urandom);
         if (k < 4) begin
            do_cmd(0, a, d, $urandom_range(0, 4));
         end else if (k < 8) begin
            do_cmd(1, a, d, $urandom_range(0, 4));
         end else begin
            if (d == 8'h57 || d == 8'h52) d = 8'hFF;
            do_cmd(2, a, d, $urandom_range(0, 4));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
